seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, giving the number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter DIV, default 400000, giving clocks per digit slot; it is a multiple of 16 and at least 32.
REQ-003 The block SHALL have parameter GUARD, default 16, giving the clocks per slot with all anodes off for anti-ghosting; GUARD < DIV/16.
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 data  in  4*N_DIGITS  hex nibbles; data[4i+3:4i] is digit i, digit 0 least significant.
REQ-007 dp  in  N_DIGITS  decimal point request per digit, active-high.
REQ-008 blank  in  N_DIGITS  force digit i dark, active-high.
REQ-009 lz_en  in  1  leading-zero suppression enable.
REQ-010 bright  in  4  brightness, 0 = 1/16 duty up to 15 = full duty.
REQ-011 seg  out  7  segments a..g on seg[6]..seg[0], active-low.
REQ-012 dp_n  out  1  decimal point, active-low.
REQ-013 an  out  N_DIGITS  digit anodes, active-low; an[i] selects digit i.
REQ-014 frame_done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-015 Slot counter cnt SHALL count 0..DIV-1 and wrap to 0; digit index idx SHALL advance by 1 on each cnt wrap, counting 0..N_DIGITS-1 and wrapping to 0.
REQ-016 data, dp, blank, lz_en and bright SHALL be captured into shadow registers only on the cycle where idx=N_DIGITS-1 and cnt=DIV-1, and on the first cycle after reset; the display SHALL use shadow values only (no mid-frame tearing).
REQ-017 Hex decode SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-018 PWM phase SHALL be cnt/(DIV/16), range 0..15; the anode of the current digit is asserted only when phase <= bright and cnt >= GUARD.
REQ-019 With lz_en=1, digit i (i>0) SHALL be suppressed when its nibble and every higher nibble are zero; digit 0 is never suppressed.
REQ-020 A suppressed or blanked digit SHALL drive seg=1111111 and dp_n=1 and keep its anode deasserted for the whole slot.
REQ-021 dp_n SHALL be 0 only during asserted-anode cycles of a digit whose shadow dp bit is 1.
REQ-022 At most one an bit SHALL be 0 in any cycle; outside the lit window an=all ones and seg=1111111.
REQ-023 seg, dp_n, an and frame_done SHALL be registered, reflecting the (idx,cnt) state of the previous cycle (1-cycle latency).
REQ-024 frame_done SHALL pulse high for exactly one cycle following the cycle where idx=N_DIGITS-1 and cnt=DIV-1.
REQ-025 Input changes outside the capture cycle SHALL have no effect until the next capture.

Reset
REQ-026 While rst=1: cnt=0, idx=0, all shadow registers 0, an=all ones, seg=1111111, dp_n=1, frame_done=0.
REQ-027 Reset asserted mid-slot or mid-frame SHALL abort the scan; scanning restarts at digit 0, cnt=0, with a fresh capture on the first cycle after release.

Structure
REQ-028 The 16-entry segment table, the all-off segment constant and the parameter legality checks SHALL live in a shared constants include used by all display blocks.
REQ-029 Hex-to-segment decode SHALL be one sub-module, hex7seg (4-bit in, 7-bit active-low out), instantiated once on the muxed nibble.
REQ-030 The block SHALL use no clock other than clk and no clock enables generated from logic.

Verification (N_DIGITS=4, DIV=32, GUARD=1)
REQ-031 After reset, data=16'h1234, bright=15, lz_en=0 -> an cycles 1110,1101,1011,0111 with seg 0000110,0010010,1001111... corrected order: digit0 '4'=1001100, digit1 '3'=0000110, digit2 '2'=0010010, digit3 '1'=1001111; each lit for cycles 1..31 of its slot; frame_done pulses every 128 cycles.
REQ-032 data=16'h0050, lz_en=1 -> digits 3 and 2 dark (an stays 1111 in their slots); digit 1 '5'=0100100, digit 0 '0'=0000001.
REQ-033 bright=3 -> each anode low only for cnt 1..7 of its slot (phase 0..3), high for cnt 8..31.
REQ-034 data changed from 16'h1111 to 16'h2222 during digit 1 -> digits 1..3 still show '1' this frame; all show '2' from the next frame.
REQ-035 dp=4'b0100, blank=4'b0001 -> dp_n=0 only during digit 2 lit cycles; digit 0 slot fully dark.
REQ-036 rst pulsed during digit 2 -> next cycle an=1111, seg=1111111; scan resumes at digit 0 with cnt=0.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg
//    Constants shared by the seven-segment display blocks.
//    SEG_TABLE : hex digit -> active-low segments a..g on bits [6:0]
//    SEG_OFF   : all segments dark
//    params_ok : legality check for the scan driver parameters
package seg_scan_driver_pkg;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0000100,   // 9
      7'b0001000,   // A
      7'b1100000,   // b
      7'b0110001,   // C
      7'b1000010,   // d
      7'b0110000,   // E
      7'b0111000    // F
   };

   // GUARD must leave at least one lit clock in the first PWM phase.
   function automatic bit params_ok(input int n_digits, input int div, input int guard);
      return (n_digits >= 2) && (n_digits <= 8) &&
             (div >= 32) && ((div % 16) == 0) &&
             (guard >= 0) && (guard < (div / 16));
   endfunction

endpackage

// File: rtl/seg_scan_driver_hex7seg.sv
// hex7seg
//    Combinational hex digit to seven-segment decoder.
//    hex   : 4-bit nibble
//    seg_n : segments a..g on [6:0], active-low
module hex7seg (
   input  logic [3:0] hex,
   output logic [6:0] seg_n
);
   import seg_scan_driver_pkg::*;

   always_comb begin
      seg_n = SEG_TABLE[hex];
   end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//    Multiplexed N-digit seven-segment scanner with PWM brightness,
//    anti-ghosting guard band, leading-zero suppression and per-frame
//    shadowing of all display inputs.
//    clk        : sole clock
//    rst        : synchronous, active-high reset
//    data       : hex nibbles, digit 0 in [3:0]
//    dp         : decimal point request per digit
//    blank      : force digit dark
//    lz_en      : leading-zero suppression enable
//    bright     : 0 = 1/16 duty .. 15 = full duty
//    seg        : segments a..g on [6:0], active-low, registered
//    dp_n       : decimal point, active-low, registered
//    an         : digit anodes, active-low, registered
//    frame_done : one-cycle pulse after the last clock of a full scan
module seg_scan_driver #(
   parameter int N_DIGITS = 4,
   parameter int DIV      = 400000,
   parameter int GUARD    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] data,
   input  logic [N_DIGITS-1:0]   dp,
   input  logic [N_DIGITS-1:0]   blank,
   input  logic                  lz_en,
   input  logic [3:0]            bright,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic [N_DIGITS-1:0]   an,
   output logic                  frame_done
);
   import seg_scan_driver_pkg::*;

   // The slot counter is split into a 4-bit PWM phase and a down-counting
   // tick timer per phase, so cnt = phase*SLICE + (SLICE-1-tick) without
   // needing a divider for cnt/(DIV/16).
   localparam int SLICE  = DIV / 16;
   localparam int TICK_W = $clog2(SLICE);
   localparam int IDX_W  = $clog2(N_DIGITS);

   localparam logic [TICK_W-1:0] TICK_MAX   = TICK_W'(SLICE - 1);
   // Within phase 0, cnt >= GUARD holds exactly when tick <= GUARD_TICK.
   localparam logic [TICK_W-1:0] GUARD_TICK = TICK_W'(SLICE - 1 - GUARD);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);

   if (!params_ok(N_DIGITS, DIV, GUARD)) begin : g_param_check
      $error("seg_scan_driver: illegal N_DIGITS/DIV/GUARD combination");
   end

   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [3:0]            phase_q, phase_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  first_q, first_d;

   logic [4*N_DIGITS-1:0] data_sh_q, data_sh_d;
   logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
   logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
   logic                  lz_sh_q, lz_sh_d;
   logic [3:0]            bright_sh_q, bright_sh_d;

   logic [6:0]            seg_q, seg_d;
   logic                  dp_n_q, dp_n_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  frame_done_q, frame_done_d;

   logic                  tick_tc;
   logic                  slot_end;
   logic                  frame_end;
   logic                  capture;
   logic [N_DIGITS-1:0]   supp;
   logic [3:0]            nibble;
   logic [6:0]            seg_dec;
   logic                  guard_ok;
   logic                  digit_dark;
   logic                  lit;
   logic [N_DIGITS-1:0]   sel_onehot;

   // scan position
   always_comb begin
      tick_tc   = (tick_q == '0);
      slot_end  = tick_tc && (phase_q == 4'd15);
      frame_end = slot_end && (idx_q == IDX_LAST);
      capture   = first_q || frame_end;

      tick_d    = tick_tc ? TICK_MAX : tick_q - 1'b1;
      phase_d   = tick_tc ? phase_q + 4'd1 : phase_q;
      idx_d     = idx_q;
      if (slot_end) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      first_d   = 1'b0;
   end

   // shadow registers, loaded only at the frame boundary or right after reset
   always_comb begin
      data_sh_d   = data_sh_q;
      dp_sh_d     = dp_sh_q;
      blank_sh_d  = blank_sh_q;
      lz_sh_d     = lz_sh_q;
      bright_sh_d = bright_sh_q;
      if (capture) begin
         data_sh_d   = data;
         dp_sh_d     = dp;
         blank_sh_d  = blank;
         lz_sh_d     = lz_en;
         bright_sh_d = bright;
      end
   end

   // supp[i]: nibble i and every nibble above it are zero; digit 0 never suppressed
   always_comb begin
      logic zero_run;
      supp     = '0;
      zero_run = lz_sh_q;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         zero_run = zero_run && (data_sh_q[4*i +: 4] == 4'h0);
         supp[i]  = zero_run;
      end
   end

   always_comb begin
      nibble = data_sh_q[{idx_q, 2'b00} +: 4];
   end

   hex7seg u_hex7seg (
      .hex   (nibble),
      .seg_n (seg_dec)
   );

   // The first cycle after reset still holds zeroed shadows, so it is kept dark.
   always_comb begin
      guard_ok    = (phase_q != 4'd0) || (tick_q <= GUARD_TICK);
      digit_dark  = blank_sh_q[idx_q] || supp[idx_q];
      lit         = !first_q && (phase_q <= bright_sh_q) && guard_ok && !digit_dark;

      sel_onehot        = '0;
      sel_onehot[idx_q] = 1'b1;

      an_d         = lit ? ~sel_onehot : '1;
      seg_d        = lit ? seg_dec : SEG_OFF;
      dp_n_d       = ~(lit && dp_sh_q[idx_q]);
      frame_done_d = frame_end;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_q       <= TICK_MAX;
         phase_q      <= 4'd0;
         idx_q        <= '0;
         first_q      <= 1'b1;
         data_sh_q    <= '0;
         dp_sh_q      <= '0;
         blank_sh_q   <= '0;
         lz_sh_q      <= 1'b0;
         bright_sh_q  <= 4'd0;
         seg_q        <= SEG_OFF;
         dp_n_q       <= 1'b1;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         phase_q      <= phase_d;
         idx_q        <= idx_d;
         first_q      <= first_d;
         data_sh_q    <= data_sh_d;
         dp_sh_q      <= dp_sh_d;
         blank_sh_q   <= blank_sh_d;
         lz_sh_q      <= lz_sh_d;
         bright_sh_q  <= bright_sh_d;
         seg_q        <= seg_d;
         dp_n_q       <= dp_n_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dp_n_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
